nios_sys_pwm_speed: RTL and testbench
=====================================

# nios_sys_pwm_speed

Avalon-MM slave that generalises the single 8-bit speed output register into a multi-channel PWM generator for the DC-motor lab platform. The Nios II core writes a shared period and a per-channel duty value; the block runs one free-running counter and drives one registered PWM bit per channel. Period and duty writes are double-buffered and take effect only at a period boundary, so software updates never produce glitched pulses. It sits on the Nios system interconnect alongside the other PIO slaves, and its `out_port` drives the motor driver pins.

## Interface
- `CHANNELS`, 4 — number of PWM outputs, 1..12.
- `WIDTH`, 16 — width of the counter, period and duty registers, 2..32.
- `clk` in 1 — system clock; all logic is on the rising edge.
- `reset` in 1 — asynchronous, active-high reset.
- `address` in 4 — word address.
- `chipselect` in 1 — slave select.
- `write_n` in 1 — active-low write strobe.
- `writedata` in 32 — write data; bits above the register width are ignored.
- `readdata` out 32 — combinational read data, zero wait states, zero-extended.
- `out_port` out CHANNELS — registered PWM outputs.

## Operation
- A write occurs on a cycle with `chipselect && !write_n`.
- Register map:
  - 0 CTRL: bit0 `en`.
  - 1 PERIOD: pending value.
  - 2 STATUS: read-only; bit0 `pend`.
  - 3 POLARITY: see Configuration.
  - 4+k DUTY[k], for k < CHANNELS.
  - Unmapped addresses read 0 and ignore writes.
- Reads of PERIOD and DUTY return the pending (written) value, not the active value.
- Each write to PERIOD or DUTY updates the pending register and sets `pend`.
- **Disabled (`en`=0):**
  - Counter `cnt` is held at 0.
  - Active registers copy the pending registers every cycle.
  - `pend` is cleared.
  - PWM term is 0.
- **Enabled:**
  - If `cnt == period_act`: `cnt` goes to 0, and active period/duty load from pending ("wrap"). Otherwise `cnt` increments.
- Load uses the pending value held before the edge. A write in the wrap cycle lands in pending, `pend` remains 1, and the value applies at the next wrap.
- `pend` clears on a wrap with no coincident write.
- Every clock: `out_port[k] <= pol[k] ^ (en & (cnt < duty_act[k]))`.
- Arithmetic: all compares are unsigned, WIDTH bits. Period length is `period_act`+1 cycles. High time is min(`duty_act`, `period_act`+1) cycles.
  - DUTY=0 gives constant low.
  - DUTY > PERIOD gives constant high.
  - PERIOD=0 wraps every cycle; output is high iff DUTY≠0.
- Clearing `en` mid-period:
  - `cnt` returns to 0 on the next edge.
  - Outputs return to the idle level (`pol`) one edge later.
  - No period completion is required.
- Reset values:
  - All registers 0.
  - `cnt` = 0.
  - `out_port` = 0.
  - `readdata` = 0 for every address after reset, except STATUS, which is also 0.

## Timing
- Write register update occurs at the edge ending the write cycle. Readback of the new value is available on the next cycle.
- Enable start:
  - The edge that sets `en` leaves `cnt`=0.
  - The next edge registers the first PWM level, so `out_port` rises one cycle after `en` reads 1.
- Output latency: `out_port` lags `cnt` by exactly one clock.
- Pending-to-active latency while enabled: at most `period_act`+1 cycles after the write.

## Configuration
- `NIOS_SYS_PWM_SPEED_POLARITY_EN` defined:
  - POLARITY (address 3) is a CHANNELS-bit read/write register, reset 0.
  - `pol[k]` inverts channel k, including the idle level.
- Macro undefined:
  - `pol` is constant 0.
  - Address 3 reads 0 and ignores writes.
  - No storage is generated.

## Test plan
- **Reset:** Assert `reset` mid-run with CH0 high.
  - `out_port` goes to 0 asynchronously.
  - After release, all reads return 0.
- **Basic PWM (CHANNELS=4):** PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=10, DUTY3=5, then CTRL=1.
  - CH0 is high 3 of every 10 cycles.
  - CH1 is always 0.
  - CH2 is always 1.
  - CH3 is 5/10.
  - The first rising edge of CH0 is one cycle after `en` reads 1.
- **Double buffering:** While running with PERIOD=9, write DUTY0=7 at `cnt`=4.
  - `pend` reads 1.
  - The current period keeps 3 high cycles.
  - The next period has 7.
  - `pend` reads 0 after the wrap.
- **Wrap-cycle write:** Write DUTY0=2 in the exact cycle `cnt`=9.
  - The following period still uses the previous pending value.
  - The value 2 applies one period later.
  - `pend` stays 1 through the first wrap.
- **Disable mid-period and PERIOD=0:**
  - Clearing `en` at `cnt`=5 gives outputs 0 two edges later and `cnt` held at 0.
  - With PERIOD=0, DUTY0=1, the output is constantly high.
- **Polarity (macro defined):** POLARITY=4'b0101 with `en`=0.
  - `out_port`=4'b0101.
  - With `en`=1 and scenario-2 settings, CH0 is low for 3 of every 10 cycles.
  - With the macro undefined, address 3 reads 0 after the write.

Source files
------------

// File: rtl/nios_sys_pwm_speed.sv
// nios_sys_pwm_speed: Avalon-MM multi-channel PWM generator with double-buffered period/duty.
// Optional feature macro: NIOS_SYS_PWM_SPEED_POLARITY_EN (POLARITY register at address 3).
module nios_sys_pwm_speed #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [CHANNELS-1:0] out_port
);

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_PERIOD = 4'd1;
  localparam logic [3:0] ADDR_STATUS = 4'd2;
  localparam logic [3:0] ADDR_POL    = 4'd3;

  logic                r_en;
  logic                r_pend;
  logic [WIDTH-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_periodPend;
  logic [WIDTH-1:0]    r_periodAct;
  logic [WIDTH-1:0]    r_dutyPend [CHANNELS];
  logic [WIDTH-1:0]    r_dutyAct  [CHANNELS];
  logic [CHANNELS-1:0] r_out;

  logic                w_write;
  logic                w_bufWrite;
  logic                w_reload;
  logic [WIDTH-1:0]    w_wdata;
  logic [CHANNELS-1:0] w_dutySel;
  logic [CHANNELS-1:0] w_pol;
  logic [CHANNELS-1:0] w_pwm;
  logic                w_unused;

  assign w_write    = chipselect && !write_n;
  assign w_wdata    = writedata[WIDTH-1:0];
  assign w_bufWrite = w_write && ((address == ADDR_PERIOD) || (|w_dutySel));
  // Active registers follow pending continuously while idle, and only at the wrap while running.
  assign w_reload   = !r_en || (r_cnt == r_periodAct);
  assign w_unused   = &{1'b0, writedata};

  always_comb begin
    w_dutySel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_dutySel[k] = (address == 4'(k + 4));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en         <= 1'b0;
      r_periodPend <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        r_dutyPend[k] <= '0;
      end
    end else if (w_write) begin
      if (address == ADDR_CTRL) begin
        r_en <= writedata[0];
      end
      if (address == ADDR_PERIOD) begin
        r_periodPend <= w_wdata;
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (w_dutySel[k]) begin
          r_dutyPend[k] <= w_wdata;
        end
      end
    end
  end

`ifdef NIOS_SYS_PWM_SPEED_POLARITY_EN
  logic [CHANNELS-1:0] r_pol;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pol <= '0;
    end else if (w_write && (address == ADDR_POL)) begin
      r_pol <= writedata[CHANNELS-1:0];
    end
  end

  assign w_pol = r_pol;
`else
  assign w_pol = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_periodAct <= '0;
      r_pend      <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        r_dutyAct[k] <= '0;
      end
    end else begin
      if (w_reload) begin
        r_cnt       <= '0;
        r_periodAct <= r_periodPend;
        for (int k = 0; k < CHANNELS; k++) begin
          r_dutyAct[k] <= r_dutyPend[k];
        end
      end else begin
        r_cnt <= r_cnt + WIDTH'(1);
      end
      // A write coinciding with a reload wins, so that value waits for the next wrap.
      if (w_bufWrite) begin
        r_pend <= 1'b1;
      end else if (w_reload) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    w_pwm = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_pwm[k] = w_pol[k] ^ (r_en & (r_cnt < r_dutyAct[k]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      r_out <= w_pwm;
    end
  end

  assign out_port = r_out;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata = {31'd0, r_en};
      ADDR_PERIOD: readdata = 32'(r_periodPend);
      ADDR_STATUS: readdata = {31'd0, r_pend};
      ADDR_POL:    readdata = 32'(w_pol);
      default: begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (w_dutySel[k]) begin
            readdata = 32'(r_dutyPend[k]);
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_nios_sys_pwm_speed.sv
// tb_nios_sys_pwm_speed: self-checking bench with a behavioural model feeding an output scoreboard.
// Expected polarity behaviour follows NIOS_SYS_PWM_SPEED_POLARITY_EN.
module tb_nios_sys_pwm_speed;

`ifdef NIOS_SYS_PWM_SPEED_POLARITY_EN
  localparam bit POL_ON = 1'b1;
`else
  localparam bit POL_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int checks = 0;
  int errors = 0;

  logic [3:0]  outQ [$];
  logic [31:0] rdQ  [$];

  logic        mEn;
  logic        mPend;
  logic [15:0] mCnt;
  logic [15:0] mPerPend;
  logic [15:0] mPerAct;
  logic [15:0] mDutyPend [4];
  logic [15:0] mDutyAct  [4];
  logic [3:0]  mPol;
  logic [3:0]  mNext;
  logic        mWr;

  nios_sys_pwm_speed #(.CHANNELS(4), .WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle model of the register/counter behaviour; pushes the out_port value each edge will register.
  initial begin
    mEn = 1'b0; mPend = 1'b0; mCnt = '0; mPerPend = '0; mPerAct = '0; mPol = '0;
    for (int k = 0; k < 4; k++) begin
      mDutyPend[k] = '0;
      mDutyAct[k]  = '0;
    end
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mEn = 1'b0; mPend = 1'b0; mCnt = '0; mPerPend = '0; mPerAct = '0; mPol = '0;
        for (int k = 0; k < 4; k++) begin
          mDutyPend[k] = '0;
          mDutyAct[k]  = '0;
        end
        outQ.delete();
      end else begin
        mWr = chipselect && !write_n;
        for (int k = 0; k < 4; k++) begin
          mNext[k] = mPol[k] ^ (mEn && (mCnt < mDutyAct[k]));
        end
        outQ.push_back(mNext);
        if (!mEn || (mCnt == mPerAct)) begin
          mCnt     = '0;
          mPerAct  = mPerPend;
          mDutyAct = mDutyPend;
          mPend    = 1'b0;
        end else begin
          mCnt = mCnt + 16'd1;
        end
        if (mWr) begin
          case (address)
            4'd0: mEn = writedata[0];
            4'd1: begin mPerPend = writedata[15:0]; mPend = 1'b1; end
            4'd3: if (POL_ON) mPol = writedata[3:0];
            4'd4, 4'd5, 4'd6, 4'd7: begin
              mDutyPend[int'(address) - 4] = writedata[15:0];
              mPend = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && outQ.size() > 0) begin
        checkOutput("out_port", {28'd0, out_port}, {28'd0, outQ.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic readCheck(input string tag, input logic [3:0] a, input logic [31:0] exp);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    rdQ.push_back(exp);
    @(negedge clk);
    checkOutput(tag, readdata, rdQ.pop_front());
    tick();
    chipselect = 1'b0;
  endtask

  task automatic waitCnt(input logic [15:0] v);
    int n;
    n = 0;
    while (mCnt != v && n < 200) begin
      tick();
      n++;
    end
    if (mCnt != v) begin
      errors++;
      $display("[TB] FAIL sync_timeout: model count %0d, wanted %0d", mCnt, v);
    end
  endtask

  task automatic countHigh(input int n, output int c0, output int c1, output int c2, output int c3);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int i = 0; i < n; i++) begin
      c0 += int'(out_port[0]);
      c1 += int'(out_port[1]);
      c2 += int'(out_port[2]);
      c3 += int'(out_port[3]);
      tick();
    end
  endtask

  initial begin
    int c0, c1, c2, c3, n;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_out", {28'd0, out_port}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      readCheck($sformatf("rst_rd%0d", a), 4'(a), 32'd0);
    end

    $display("[TB] basic PWM");
    applyStimulus(4'd1, 32'hABCD_0009);
    applyStimulus(4'd4, 32'd3);
    applyStimulus(4'd5, 32'd0);
    applyStimulus(4'd6, 32'd10);
    applyStimulus(4'd7, 32'd5);
    applyStimulus(4'd9, 32'h1234);
    readCheck("period_rd", 4'd1, 32'd9);
    readCheck("duty0_rd", 4'd4, 32'd3);
    readCheck("duty2_rd", 4'd6, 32'd10);
    readCheck("duty3_rd", 4'd7, 32'd5);
    readCheck("unmapped_rd", 4'd9, 32'd0);
    applyStimulus(4'd0, 32'd1);
    checkOutput("ch0_pre_rise", {31'd0, out_port[0]}, 32'd0);
    tick();
    checkOutput("ch0_first_rise", {31'd0, out_port[0]}, 32'd1);
    countHigh(10, c0, c1, c2, c3);
    checkOutput("basic_ch0_high", c0, 32'd3);
    checkOutput("basic_ch1_high", c1, 32'd0);
    checkOutput("basic_ch2_high", c2, 32'd10);
    checkOutput("basic_ch3_high", c3, 32'd5);
    readCheck("ctrl_rd", 4'd0, 32'd1);

    $display("[TB] double buffering");
    waitCnt(16'd1);
    countHigh(3, c0, c1, c2, c3);
    checkOutput("db_head_high", c0, 32'd3);
    applyStimulus(4'd4, 32'd7);
    readCheck("db_pend_set", 4'd2, 32'd1);
    countHigh(5, c0, c1, c2, c3);
    checkOutput("db_tail_high", c0, 32'd0);
    countHigh(10, c0, c1, c2, c3);
    checkOutput("db_next_high", c0, 32'd7);
    readCheck("db_pend_clr", 4'd2, 32'd0);

    $display("[TB] wrap-cycle write");
    waitCnt(16'd9);
    applyStimulus(4'd4, 32'd2);
    readCheck("wrap_pend_held", 4'd2, 32'd1);
    countHigh(10, c0, c1, c2, c3);
    checkOutput("wrap_period1_high", c0, 32'd7);
    countHigh(10, c0, c1, c2, c3);
    checkOutput("wrap_period2_high", c0, 32'd2);
    readCheck("wrap_pend_clr", 4'd2, 32'd0);

    $display("[TB] disable mid-period and PERIOD=0");
    waitCnt(16'd5);
    applyStimulus(4'd0, 32'd0);
    checkOutput("dis_lag_ch2", {31'd0, out_port[2]}, 32'd1);
    tick();
    checkOutput("dis_idle", {28'd0, out_port}, 32'd0);
    applyStimulus(4'd1, 32'd0);
    applyStimulus(4'd4, 32'd1);
    applyStimulus(4'd0, 32'd1);
    tick();
    countHigh(10, c0, c1, c2, c3);
    checkOutput("p0_ch0_high", c0, 32'd10);
    checkOutput("p0_ch1_high", c1, 32'd0);

    $display("[TB] polarity");
    applyStimulus(4'd0, 32'd0);
    applyStimulus(4'd3, 32'h5);
    tick();
    tick();
    checkOutput("pol_idle", {28'd0, out_port}, POL_ON ? 32'h5 : 32'h0);
    readCheck("pol_rd", 4'd3, POL_ON ? 32'h5 : 32'h0);
    applyStimulus(4'd1, 32'd9);
    applyStimulus(4'd4, 32'd3);
    applyStimulus(4'd0, 32'd1);
    waitCnt(16'd1);
    countHigh(10, c0, c1, c2, c3);
    checkOutput("pol_ch0_high", c0, POL_ON ? 32'd7 : 32'd3);

    $display("[TB] asynchronous reset");
    n = 0;
    while (out_port[0] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("ch0_high_before_rst", {31'd0, out_port[0]}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_out", {28'd0, out_port}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      readCheck($sformatf("rst2_rd%0d", a), 4'(a), 32'd0);
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
